// File: rtl/rx_arb_pkg.sv
// Shared types and constants for the RX stream arbiter.
package rx_arb_pkg;
   typedef enum logic {IDLE, GRANT} arb_state_t;
   localparam int STAT_W    = 16;
   localparam int MAX_PORTS = 8;
endpackage

// File: rtl/rr_picker.sv
// Rotating priority encoder: first requester after last_grant, wrapping mod NUM_PORTS.
module rr_picker
   import rx_arb_pkg::*;
#(
   parameter  int NUM_PORTS = 4,
   localparam int IDX_W     = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [IDX_W-1:0]     last_grant,
   output logic                 any_req,
   output logic [IDX_W-1:0]     pick
);

   int cand;

   // Walk from the farthest candidate to the nearest so the nearest set bit wins.
   always_comb begin
      any_req = |req;
      pick    = '0;
      cand    = 0;
      for (int k = NUM_PORTS; k >= 1; k--) begin
         cand = (int'(last_grant) + k) % NUM_PORTS;
         if (req[cand[IDX_W-1:0]]) pick = cand[IDX_W-1:0];
      end
   end

endmodule

// File: rtl/rx_stream_arbiter.sv
// Packet-level round-robin merge of NUM_PORTS byte streams into one registered stream.
// Define RX_ARB_STATS_EN to add per-source packet counters (pkt_count, stats_clr).
module rx_stream_arbiter
   import rx_arb_pkg::*;
#(
   parameter  int NUM_PORTS = 4,
   localparam int IDX_W     = $clog2(NUM_PORTS)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_PORTS-1:0]   in_tvalid,
   output logic [NUM_PORTS-1:0]   in_tready,
   input  logic [8*NUM_PORTS-1:0] in_tdata,
   input  logic [NUM_PORTS-1:0]   in_tlast,
   output logic                   out_tvalid,
   input  logic                   out_tready,
   output logic [7:0]             out_tdata,
   output logic                   out_tlast,
`ifdef RX_ARB_STATS_EN
   output logic [STAT_W*NUM_PORTS-1:0] pkt_count,
   input  logic                   stats_clr,
`endif
   output logic                   grant_active,
   output logic [IDX_W-1:0]       grant_idx
);

   arb_state_t       state_reg;
   logic [IDX_W-1:0] grant_idx_reg;
   logic [IDX_W-1:0] last_grant_reg;
   logic             out_tvalid_reg;
   logic [7:0]       out_tdata_reg;
   logic             out_tlast_reg;

   logic             any_req;
   logic [IDX_W-1:0] pick;
   logic             slot_free;
   logic             accept;
   logic [7:0]       beat_data;
   logic             beat_last;

   rr_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
      .req        (in_tvalid),
      .last_grant (last_grant_reg),
      .any_req    (any_req),
      .pick       (pick)
   );

   // The output slot can take a beat when empty or being drained this cycle.
   assign slot_free = !out_tvalid_reg || out_tready;
   assign accept    = (state_reg == GRANT) && in_tvalid[grant_idx_reg] && slot_free;
   assign beat_data = in_tdata[{grant_idx_reg, 3'b000} +: 8];
   assign beat_last = in_tlast[grant_idx_reg];

   always_comb begin
      in_tready = '0;
      if (state_reg == GRANT) in_tready[grant_idx_reg] = slot_free;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         grant_idx_reg  <= '0;
         last_grant_reg <= IDX_W'(NUM_PORTS - 1);
         out_tvalid_reg <= 1'b0;
         out_tdata_reg  <= '0;
         out_tlast_reg  <= 1'b0;
      end else begin
         if (accept) begin
            out_tvalid_reg <= 1'b1;
            out_tdata_reg  <= beat_data;
            out_tlast_reg  <= beat_last;
         end else if (out_tready) begin
            out_tvalid_reg <= 1'b0;
         end
         case (state_reg)
            IDLE: begin
               if (any_req) begin
                  grant_idx_reg  <= pick;
                  last_grant_reg <= pick;
                  state_reg      <= GRANT;
               end
            end
            GRANT: begin
               if (accept && beat_last) state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign out_tvalid   = out_tvalid_reg;
   assign out_tdata    = out_tdata_reg;
   assign out_tlast    = out_tlast_reg;
   assign grant_active = (state_reg == GRANT);
   assign grant_idx    = grant_idx_reg;

`ifdef RX_ARB_STATS_EN
   logic [STAT_W-1:0] cnt_reg [NUM_PORTS];

   for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_stat
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            cnt_reg[gi] <= '0;
         else if (stats_clr)
            cnt_reg[gi] <= '0;
         else if (accept && beat_last && grant_idx_reg == IDX_W'(gi))
            cnt_reg[gi] <= cnt_reg[gi] + STAT_W'(1);
      end
      assign pkt_count[gi*STAT_W +: STAT_W] = cnt_reg[gi];
   end
`endif

endmodule

// File: tb/tb_rx_stream_arbiter.sv
// Scoreboard bench for rx_stream_arbiter: per-source packet queues drive the inputs,
// a monitor pops expected beats and grants as the DUT presents them.
module tb_rx_stream_arbiter;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   in_tvalid = '0;
   logic [N-1:0]   in_tready;
   logic [8*N-1:0] in_tdata = '0;
   logic [N-1:0]   in_tlast = '0;
   logic           out_tvalid;
   logic           out_tready = 1'b1;
   logic [7:0]     out_tdata;
   logic           out_tlast;
   logic           grant_active;
   logic [1:0]     grant_idx;
`ifdef RX_ARB_STATS_EN
   logic [16*N-1:0] pkt_count;
   logic            stats_clr = 1'b0;
`endif

   rx_stream_arbiter #(.NUM_PORTS(N)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_tvalid    (in_tvalid),
      .in_tready    (in_tready),
      .in_tdata     (in_tdata),
      .in_tlast     (in_tlast),
      .out_tvalid   (out_tvalid),
      .out_tready   (out_tready),
      .out_tdata    (out_tdata),
      .out_tlast    (out_tlast),
`ifdef RX_ARB_STATS_EN
      .pkt_count    (pkt_count),
      .stats_clr    (stats_clr),
`endif
      .grant_active (grant_active),
      .grant_idx    (grant_idx)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int pops   = 0;
   int pop_cyc[$];
   logic [8:0] src_q [N][$];   // {last, data} per source
   logic [8:0] sb[$];          // expected output beats in order
   int         gq[$];          // expected grant sequence
   logic       prev_ga = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   task automatic send(input int port, input logic [7:0] d, input logic last);
      src_q[port].push_back({last, d});
      sb.push_back({last, d});
   endtask

   // Source driver: present queue heads at negedge, retire on handshake just before posedge.
   initial begin
      forever begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
               in_tvalid[i]       = 1'b1;
               in_tdata[8*i +: 8] = src_q[i][0][7:0];
               in_tlast[i]        = src_q[i][0][8];
            end else begin
               in_tvalid[i]       = 1'b0;
               in_tdata[8*i +: 8] = 8'hEE;
               in_tlast[i]        = 1'b0;
            end
         end
         #3;
         for (int i = 0; i < N; i++)
            if (in_tvalid[i] && in_tready[i]) void'(src_q[i].pop_front());
      end
   end

   // Monitor: output beats and new grants against the scoreboards.
   initial begin
      logic [8:0] e;
      forever begin
         @(negedge clk);
         #3;
         cyc++;
         if (rst_n) begin
            if (grant_active && !prev_ga) begin
               if (gq.size() == 0) chk("unexpected_grant", int'(grant_idx), -1);
               else chk("grant_idx", int'(grant_idx), gq.pop_front());
            end
            prev_ga = grant_active;
            if (out_tvalid && out_tready) begin
               if (sb.size() == 0) begin
                  chk("unexpected_beat", int'(out_tdata), -1);
               end else begin
                  e = sb.pop_front();
                  chk("beat_data", int'(out_tdata), int'(e[7:0]));
                  chk("beat_last", int'(out_tlast), int'(e[8]));
               end
               pops++;
               pop_cyc.push_back(cyc);
            end
         end else begin
            prev_ga = 1'b0;
         end
      end
   end

   task automatic start_reset();
      @(negedge clk);
      rst_n = 1'b0;
      for (int i = 0; i < N; i++) src_q[i].delete();
      pops = 0;
      pop_cyc.delete();
   endtask

   task automatic end_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_drain(input string nm);
      int left;
      left = 0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         left = sb.size() + gq.size();
         for (int i = 0; i < N; i++) left += src_q[i].size();
         if (left == 0) break;
      end
      chk(nm, left, 0);
   endtask

   task automatic wait_grant(input string nm);
      logic seen;
      seen = 1'b0;
      for (int n = 0; n < 50 && !seen; n++) begin
         @(negedge clk);
         #3;
         seen = grant_active;
      end
      chk(nm, int'(seen), 1);
   endtask

   initial begin
      logic done;
      // Reset values
      #2;
      chk("rst_out_tvalid", int'(out_tvalid), 0);
      chk("rst_out_tdata", int'(out_tdata), 0);
      chk("rst_out_tlast", int'(out_tlast), 0);
      chk("rst_in_tready", int'(in_tready), 0);
      chk("rst_grant_active", int'(grant_active), 0);
      chk("rst_grant_idx", int'(grant_idx), 0);

      // 1: single 3-byte packet from source 2
      start_reset();
      send(2, 8'h11, 1'b0); send(2, 8'h22, 1'b0); send(2, 8'h33, 1'b1);
      gq.push_back(2);
      end_reset();
      wait_drain("t1_drain");
      if (pop_cyc.size() == 3) chk("t1_consecutive", pop_cyc[2] - pop_cyc[0], 2);
      else chk("t1_pop_count", pop_cyc.size(), 3);
      @(negedge clk); #3;
      chk("t1_back_idle", int'(grant_active), 0);

      // 2: all sources requesting, round-robin order with one bubble per packet
      start_reset();
      send(0, 8'hA0, 1'b0); send(0, 8'hA1, 1'b1);
      send(1, 8'h10, 1'b0); send(1, 8'h11, 1'b1);
      send(2, 8'h20, 1'b0); send(2, 8'h21, 1'b1);
      send(3, 8'h30, 1'b0); send(3, 8'h31, 1'b1);
      send(0, 8'hB0, 1'b0); send(0, 8'hB1, 1'b1);
      gq.push_back(0); gq.push_back(1); gq.push_back(2); gq.push_back(3); gq.push_back(0);
      // Source 0's second packet sits behind its first in the same queue.
      sb.delete();
      sb.push_back(9'h0A0); sb.push_back(9'h1A1); sb.push_back(9'h010); sb.push_back(9'h111);
      sb.push_back(9'h020); sb.push_back(9'h121); sb.push_back(9'h030); sb.push_back(9'h131);
      sb.push_back(9'h0B0); sb.push_back(9'h1B1);
      end_reset();
      wait_drain("t2_drain");
      if (pop_cyc.size() == 10) chk("t2_span", pop_cyc[9] - pop_cyc[0], 13);
      else chk("t2_pop_count", pop_cyc.size(), 10);

      // 3: backpressure 1,0,0,1 mid-packet on source 1
      start_reset();
      end_reset();
      send(1, 8'h41, 1'b0); send(1, 8'h42, 1'b0); send(1, 8'h43, 1'b0);
      send(1, 8'h44, 1'b0); send(1, 8'h45, 1'b1);
      gq.push_back(1);
      wait_grant("t3_granted");
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         out_tready = 1'b0;
         #3;
         chk("t3_hold_valid", int'(out_tvalid), 1);
         chk("t3_in_tready_low", int'(in_tready[1]), 0);
      end
      @(negedge clk);
      out_tready = 1'b1;
      wait_drain("t3_drain");

      // 4: source 3 requests mid-packet of source 0, no preemption
      start_reset();
      end_reset();
      send(0, 8'h51, 1'b0); send(0, 8'h52, 1'b0); send(0, 8'h53, 1'b0);
      send(0, 8'h54, 1'b0); send(0, 8'h55, 1'b1);
      gq.push_back(0);
      wait_grant("t4_granted");
      send(3, 8'h61, 1'b0); send(3, 8'h62, 1'b1);
      gq.push_back(3);
      @(negedge clk); @(negedge clk); #3;
      chk("t4_no_preempt", int'(grant_idx), 0);
      chk("t4_src3_waits", int'(in_tready[3]), 0);
      wait_drain("t4_drain");

      // 5: asynchronous reset after 2 bytes of a 5-byte packet
      start_reset();
      end_reset();
      src_q[2].push_back(9'h071); src_q[2].push_back(9'h072); src_q[2].push_back(9'h073);
      src_q[2].push_back(9'h074); src_q[2].push_back(9'h175);
      sb.push_back(9'h071); sb.push_back(9'h072);
      gq.push_back(2);
      done = 1'b0;
      for (int n = 0; n < 50 && !done; n++) begin
         @(negedge clk);
         done = (pops >= 2);
      end
      chk("t5_two_bytes", int'(done), 1);
      #1;
      chk("t5_pre_valid", int'(out_tvalid), 1);
      rst_n = 1'b0;
      #1;
      chk("t5_async_valid", int'(out_tvalid), 0);
      chk("t5_async_ready", int'(in_tready), 0);
      chk("t5_async_grant", int'(grant_active), 0);
      for (int i = 0; i < N; i++) src_q[i].delete();
      send(3, 8'h91, 1'b1);
      send(1, 8'h81, 1'b1);
      sb.delete();
      sb.push_back(9'h181); sb.push_back(9'h191);
      gq.push_back(1); gq.push_back(3);
      end_reset();
      wait_drain("t5_drain");

`ifdef RX_ARB_STATS_EN
      // 6: packet counters and clear-over-increment
      start_reset();
      end_reset();
      send(1, 8'hC1, 1'b1); send(1, 8'hC2, 1'b1); send(1, 8'hC3, 1'b1);
      gq.push_back(1); gq.push_back(1); gq.push_back(1);
      wait_drain("t6_drain");
      chk("t6_count1", int'(pkt_count[31:16]), 3);
      chk("t6_count0", int'(pkt_count[15:0]), 0);
      send(1, 8'hC4, 1'b1);
      gq.push_back(1);
      done = 1'b0;
      for (int n = 0; n < 50 && !done; n++) begin
         @(negedge clk);
         #3;
         if (in_tvalid[1] && in_tready[1] && in_tlast[1]) begin
            stats_clr = 1'b1;
            done = 1'b1;
            @(posedge clk);
            #1;
            stats_clr = 1'b0;
         end
      end
      chk("t6_clr_hit", int'(done), 1);
      chk("t6_cleared", int'(pkt_count[31:16]), 0);
      wait_drain("t6_drain2");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rx_stream_arbiter.md
Name: rx_stream_arbiter

Overview:
- Packet-level round-robin arbiter that merges NUM_PORTS byte-wide AXI-Stream RX sources into one stream.
- Its output feeds the MAC address filter's input.
- A grant is held for a whole packet (until tlast), so packets are never interleaved.
- The output is registered through a one-entry pipeline stage with full valid/ready backpressure.

Parameters:
- NUM_PORTS, 4, number of input sources; legal range 2..8.
- IDX_W, $clog2(NUM_PORTS), width of the grant index (derived; do not override).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_tvalid  in  NUM_PORTS  per-source valid; bit i belongs to source i.
- in_tready  out  NUM_PORTS  per-source ready.
- in_tdata  in  8*NUM_PORTS  per-source byte; source i occupies [8i+7:8i].
- in_tlast  in  NUM_PORTS  per-source end-of-packet.
- out_tvalid  out  1  merged stream valid (registered).
- out_tready  in  1  downstream ready.
- out_tdata  out  8  merged stream byte (registered).
- out_tlast  out  1  merged stream end-of-packet (registered).
- grant_active  out  1  high while a packet grant is held.
- grant_idx  out  IDX_W  currently or last granted source.

Behaviour:
Reset values:
- out_tvalid=0, out_tdata=0, out_tlast=0, in_tready=0 (all bits).
- grant_active=0, grant_idx=0.
- Round-robin pointer last_grant=NUM_PORTS-1, so source 0 has top priority after reset.

FSM, states IDLE and GRANT:
- IDLE:
  - If any in_tvalid is high, pick the first set bit searching last_grant+1, last_grant+2, ... (mod NUM_PORTS).
  - On that cycle, register grant_idx=pick, last_grant=pick, and go to GRANT.
  - in_tready is all-zero in IDLE.
- GRANT:
  - in_tready[grant_idx] = !out_tvalid || out_tready; all other in_tready bits are 0.
  - A beat is accepted when in_tvalid[grant_idx] && in_tready[grant_idx]. It loads out_tdata/out_tlast and sets out_tvalid=1 on the next edge.
  - On an accepted beat with in_tlast=1, go to IDLE.
- The output register clears out_tvalid when out_tready=1 and no new beat is loaded in the same cycle.
- Simultaneous downstream pop and upstream accept: the register is overwritten and out_tvalid stays 1.
- Throughput: 1 byte/cycle inside a packet. One mandatory bubble cycle (IDLE) between packets. Latency is 1 cycle from input accept to out_tvalid.
- grant_active = (state == GRANT).
- Requests arriving while in GRANT are ignored until IDLE; no preemption.
- A granted source dropping in_tvalid mid-packet: the grant is held indefinitely with no timeout.
- Single requester: re-granted back-to-back every packet (2 cycles per 1-byte packet).
- Reset asserted mid-packet: all state clears immediately (asynchronous). The partial packet is abandoned and not completed on the output.
- Data driven on non-granted ports is never sampled.

Optional Feature:
- Macro: RX_ARB_STATS_EN.
- Defined:
  - Adds output pkt_count, 16*NUM_PORTS wide; counter i occupies [16i+15:16i].
  - Counter i increments by 1 on each accepted tlast beat from source i.
  - Counters wrap 16'hFFFF -> 0 and reset to 0.
  - Adds input stats_clr (1 bit). When high, it zeroes all counters synchronously and takes precedence over an increment in the same cycle.
- Not defined: pkt_count and stats_clr ports do not exist and no counter logic is built.

Decomposition:
- Package rx_arb_pkg holds:
  - typedef enum logic {IDLE, GRANT} arb_state_t;
  - localparam STAT_W = 16;
  - localparam MAX_PORTS = 8.
- Sub-module rr_picker: purely combinational rotating priority encoder.
  - Inputs: req[NUM_PORTS] and last_grant.
  - Outputs: any_req and pick[IDX_W].

Test Plan:
1. Reset release with only source 2 sending a 3-byte packet 0x11, 0x22, 0x33 (last on 0x33), out_tready=1 -> grant_idx=2; output bytes 11, 22, 33 on consecutive cycles; out_tlast only on 33; back to IDLE.
2. All four sources hold valid with 2-byte packets, out_tready=1 -> grant order 0, 1, 2, 3, 0; no interleaving; one idle cycle between packets.
3. Source 1 mid-packet while out_tready is toggled 1,0,0,1 -> no byte lost or duplicated; in_tready[1] is low while out_tvalid=1 and out_tready=0.
4. Source 0 mid-packet while source 3 raises valid -> source 3 waits until source 0's tlast is accepted, then is granted next.
5. rst_n pulsed low after 2 bytes of a 5-byte packet -> out_tvalid drops at once; after release the first grant is to the lowest-index requester.
6. With RX_ARB_STATS_EN defined, send 3 packets from source 1 and pulse stats_clr coincident with a tlast -> pkt_count[1] reads 3 before the pulse and 0 after it.
